// File: rtl/list_sum_pkg.sv
// Shared definitions for the list_sum sequencer: controller state encoding.
package list_sum_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/list_sum_fsm.sv
// Controller for list_sum: turns start/len_zero/cnt_one into load enables
// for the datapath registers plus the busy/done status outputs.
//
// Handshake: start is a request level sampled only in IDLE (no ready signal;
// busy=1 means requests are being ignored, never queued); done is a single
// cycle pulse marking the cycle in which the datapath result is final.
module list_sum_fsm
    import list_sum_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               len_zero,
    input  logic               cnt_one,
    output logic               clr,
    output logic               ld_sum,
    output logic               ld_addr,
    output logic               ld_cnt,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] state
);

    state_t cur, nxt;

    assign state = cur;

    // State register; reset returns to IDLE regardless of start.
    always_ff @(posedge clk) begin
        if (rst) cur <= S_IDLE;
        else     cur <= nxt;
    end

    // Next-state and enable decode; clr and ld_cnt together mean "load len".
    always_comb begin
        nxt     = cur;
        clr     = 1'b0;
        ld_sum  = 1'b0;
        ld_addr = 1'b0;
        ld_cnt  = 1'b0;
        busy    = (cur != S_IDLE);
        done    = 1'b0;
        case (cur)
            S_IDLE: begin
                if (start) begin
                    clr    = 1'b1;
                    ld_cnt = 1'b1;
                    nxt    = len_zero ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                nxt = S_ADD;
            end
            S_ADD: begin
                ld_sum  = 1'b1;
                ld_addr = 1'b1;
                ld_cnt  = 1'b1;
                nxt     = cnt_one ? S_DONE : S_RD;
            end
            S_DONE: begin
                done = 1'b1;
                nxt  = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

endmodule

// File: rtl/list_sum.sv
// list_sum: sums len words from a synchronous-read memory starting at 0.
// The top holds the load-enable datapath; list_sum_fsm sequences it.
module list_sum
    import list_sum_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W:0]    len,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [WIDTH-1:0]   mem_data,
    output logic [WIDTH-1:0]   sum,
    output logic               overflow,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] dbg_state
);

    logic              clr, ld_sum, ld_addr, ld_cnt;
    logic              len_zero, cnt_one;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   cnt;
    logic [WIDTH:0]    add_res;

    assign len_zero = (len == '0);
    assign cnt_one  = (cnt == {{ADDR_W{1'b0}}, 1'b1});
    assign add_res  = {1'b0, sum} + {1'b0, mem_data};
    assign mem_addr = addr;

    list_sum_fsm u_fsm (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len_zero(len_zero),
        .cnt_one (cnt_one),
        .clr     (clr),
        .ld_sum  (ld_sum),
        .ld_addr (ld_addr),
        .ld_cnt  (ld_cnt),
        .busy    (busy),
        .done    (done),
        .state   (dbg_state)
    );

    // Accumulator and sticky carry: cleared on a new request, loaded in ADD.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum      <= '0;
            overflow <= 1'b0;
        end else if (ld_sum) begin
            sum      <= add_res[WIDTH-1:0];
            overflow <= overflow | add_res[WIDTH];
        end
    end

    // Address register: zeroed on a new request, stepped (and wrapping) in ADD.
    always_ff @(posedge clk) begin
        if (rst || clr) addr <= '0;
        else if (ld_addr) addr <= addr + 1'b1;
    end

    // Remaining-word counter: takes len on a new request, counts down in ADD.
    always_ff @(posedge clk) begin
        if (rst)         cnt <= '0;
        else if (ld_cnt) cnt <= clr ? len : cnt - 1'b1;
    end

endmodule
